// File: rtl/divu_iter.sv
// Iterative 32-bit unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, quotient to LO (q) and remainder to HI (r).
module divu_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        done,
  output logic        dbz
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvsr;
  logic [4:0]  r_cnt;
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic        r_dbz;
  logic        r_done;

  state_t      w_state_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_dvsr_nxt;
  logic [4:0]  w_cnt_nxt;
  logic [31:0] w_q_nxt;
  logic [31:0] w_r_nxt;
  logic        w_dbz_nxt;
  logic        w_done_nxt;

  // 33-bit trial keeps the borrow even when the shifted remainder exceeds 32 bits
  logic [32:0] w_partial;
  logic [32:0] w_trial;

  assign w_partial = {r_rem, r_quo[31]};
  assign w_trial   = w_partial - {1'b0, r_dvsr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_quo   <= w_quo_nxt;
      r_rem   <= w_rem_nxt;
      r_dvsr  <= w_dvsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_dbz   <= w_dbz_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_quo_nxt   = r_quo;
    w_rem_nxt   = r_rem;
    w_dvsr_nxt  = r_dvsr;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_dbz_nxt   = r_dbz;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_quo_nxt   = dividend;
          w_dvsr_nxt  = divisor;
          w_rem_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (!w_trial[32]) begin
          w_rem_nxt = w_trial[31:0];
          w_quo_nxt = {r_quo[30:0], 1'b1};
        end else begin
          w_rem_nxt = w_partial[31:0];
          w_quo_nxt = {r_quo[30:0], 1'b0};
        end
        w_cnt_nxt = r_cnt + 5'd1;
        // results publish on the same edge as the 32nd step
        if (r_cnt == 5'd31) begin
          w_q_nxt     = w_quo_nxt;
          w_r_nxt     = w_rem_nxt;
          w_dbz_nxt   = (r_dvsr == 32'd0);
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign q    = r_q;
  assign r    = r_r;
  assign busy = (r_state == S_CALC);
  assign done = r_done;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_divu_iter.sv
// Self-checking bench for divu_iter: directed corner cases plus a randomized
// back-to-back regression against a plain-arithmetic reference model.
module tb_divu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        dbz;

  int n_checks = 0;
  int n_fail   = 0;

  divu_iter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eq, output logic [31:0] er);
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Counts edges from the accept edge until done is seen; optionally pokes a
  // start with fresh operands at step poke_at to confirm it is ignored.
  task automatic wait_done(input int poke_at, output int lat, output int busy_err);
    lat      = 0;
    busy_err = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_err++;
      if (lat == poke_at) begin
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int lat, berr;
    ref_div(a, b, eq, er);
    start_op(a, b);
    wait_done(-1, lat, berr);
    check({tag, "_lat"}, lat, 32);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, b == 32'd0});
    check({tag, "_busy_during"}, berr, 0);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat, berr, nd, nb;
    logic [31:0] a, b, eq, er, pq, pr;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("d100_7", 32'd100, 32'd7);
    check("d100_7_q14", q, 32'd14);
    check("d100_7_r2", r, 32'd2);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    run_op("ff_1", 32'hFFFF_FFFF, 32'd1);
    run_op("ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("ff_ff_q1", q, 32'd1);
    run_op("d3_10", 32'd3, 32'd10);
    run_op("dbz5", 32'd5, 32'd0);
    check("dbz5_q", q, 32'hFFFF_FFFF);
    check("dbz5_r", r, 32'd5);
    check("dbz5_flag", {31'd0, dbz}, 32'd1);
    run_op("d9_3", 32'd9, 32'd3);
    check("d9_3_dbz_clear", {31'd0, dbz}, 32'd0);

    // start while busy must be ignored
    start_op(32'd1000, 32'd10);
    wait_done(10, lat, berr);
    check("poke_lat", lat, 32);
    check("poke_q", q, 32'd100);
    check("poke_r", r, 32'd0);
    nd = 0;
    nb = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    check("poke_no_extra_done", nd, 0);
    check("poke_no_extra_busy", nb, 0);

    // asynchronous reset mid-operation
    start_op(32'd1000, 32'd10);
    repeat (16) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_q", q, 32'd0);
    check("arst_r", r, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) nd++;
    end
    check("arst_no_done", nd, 0);
    run_op("d50_8", 32'd50, 32'd8);
    check("d50_8_q6", q, 32'd6);
    check("d50_8_r2", r, 32'd2);

    // randomized back-to-back regression
    pq = q;
    pr = r;
    for (int i = 0; i < 1200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd1;
        1: begin a = $urandom_range(0, 1000); b = a + 32'd1 + $urandom_range(0, 100000); end
        2: b = 32'd1 << $urandom_range(0, 31);
        3: b = (i % 50 == 0) ? 32'd0 : 32'd1 << $urandom_range(0, 31);
        4: b = $urandom_range(1, 255);
        5: b = a;
        default: b = $urandom;
      endcase
      ref_div(a, b, eq, er);
      start_op(a, b);
      check("rnd_hold_q", q, pq);
      check("rnd_hold_r", r, pr);
      wait_done(-1, lat, berr);
      check("rnd_lat", lat, 31 + 1);
      check("rnd_q", q, eq);
      check("rnd_r", r, er);
      check("rnd_dbz", {31'd0, dbz}, {31'd0, b == 32'd0});
      if (lat >= 40) begin
        $display("FAIL rnd_timeout: got no done expected done within 32 edges");
        break;
      end
      pq = eq;
      pr = er;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
